th99_chls: RTL and testbench

- Memory-mapped signal-processing and display block on an 8051-style multiplexed external bus.
- Runs a masked 7-tap FIR filter on a stream of 8-bit samples and shows the saturated result as three 7-segment digits.
- Keeps a time-of-day clock shown as 12-hour HH:MM on four 7-segment digits, plus an A/P glyph on a 16-segment display.
- The CPU writes the filter coefficients, tap mask, hour and minute through the bus.

---
 rtl/th99_chls_pkg.sv | 23 ++
 rtl/th99_chls_seg7_decode.sv | 12 +
 rtl/th99_chls.sv | 175 +++++++++++++++++
 tb/tb_th99_chls.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/th99_chls_pkg.sv
// Shared constants for th99_chls: bus register map, display glyph tables, filter limits.
package th99_chls_pkg;
  localparam logic [15:0] ADDR_COEF0  = 16'd0;
  localparam logic [15:0] ADDR_COEF1  = 16'd1;
  localparam logic [15:0] ADDR_COEF2  = 16'd2;
  localparam logic [15:0] ADDR_COEF3  = 16'd3;
  localparam logic [15:0] ADDR_COEF4  = 16'd4;
  localparam logic [15:0] ADDR_COEF5  = 16'd5;
  localparam logic [15:0] ADDR_COEF6  = 16'd6;
  localparam logic [15:0] ADDR_MASK   = 16'd7;
  localparam logic [15:0] ADDR_HOUR   = 16'd8;
  localparam logic [15:0] ADDR_MINUTE = 16'd9;

  localparam int          NUM_TAPS   = 7;
  localparam logic [9:0]  MAX_RESULT = 10'd999;

  // Active-high g..a; entry [d] is the glyph for decimal digit d.
  localparam logic [9:0][6:0] SEG7_TAB = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                          7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

  localparam logic [15:0] AP_A = 16'h03CF;
  localparam logic [15:0] AP_P = 16'h03C7;
endpackage

// File: rtl/th99_chls_seg7_decode.sv
// Single decimal digit to 7-segment glyph; non-decimal codes blank the digit.
module seg7_decode
  import th99_chls_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h00;
    if (digit_i <= 4'd9) seg_o = SEG7_TAB[digit_i];
  end
endmodule

// File: rtl/th99_chls.sv
// Bus-mapped 7-tap masked FIR with saturated 3-digit readout, plus a 12-hour
// HH:MM time-of-day display with A/P glyph.
module th99_chls
  import th99_chls_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 100000000,
  parameter logic [35:0] MINUTE_TICKS = 36'd60 * 36'(CLK_FREQ_HZ)
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic [7:0]  abus,
  input  logic        ale,
  input  logic        r_n,
  input  logic        w_n,
  inout  wire  [7:0]  dbus,
  input  logic        pe_n,
  input  logic [7:0]  sig_in,
  output logic [6:0]  sig_digi2,
  output logic [6:0]  sig_digi1,
  output logic [6:0]  sig_digi0,
  output logic [6:0]  hour_digi1,
  output logic [6:0]  hour_digi0,
  output logic [6:0]  minute_digi1,
  output logic [6:0]  minute_digi0,
  output logic [15:0] ap
);
  logic ale_q, ale_prev_q, w_q, w_prev_q, cs_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q, rdata;
  logic [NUM_TAPS-1:0][7:0] coef_q, x_q;
  logic [NUM_TAPS-1:0]      mask_q;
  logic [4:0]  hour_q, hour_d, h12;
  logic [5:0]  minute_q, minute_d;
  logic [35:0] pre_q, pre_d;
  logic        shift_q;
  logic [9:0]  result_q;
  logic [18:0] sum;
  logic        ale_fall, w_rise, time_wr;
  logic [6:0][3:0] dig_val;
  logic [6:0][6:0] dig_seg;

  // Strobes are synchronised first so edges are judged on clean registered levels.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ale_q <= 1'b0; ale_prev_q <= 1'b0;
      w_q   <= 1'b1; w_prev_q   <= 1'b1;
      cs_q  <= 1'b1;
    end else begin
      ale_q <= ale;  ale_prev_q <= ale_q;
      w_q   <= w_n;  w_prev_q   <= w_q;
      cs_q  <= cs_n;
    end
  end

  assign ale_fall = ale_prev_q & ~ale_q & ~cs_q;
  assign w_rise   = ~w_prev_q & w_q & ~cs_q;
  assign time_wr  = w_rise && ((addr_q == ADDR_HOUR && wdata_q < 8'd24) ||
                               (addr_q == ADDR_MINUTE && wdata_q < 8'd60));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (ale_fall) addr_q <= {abus, dbus};
      if (!w_n)     wdata_q <= dbus;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      coef_q <= '0;
      mask_q <= '0;
    end else if (w_rise) begin
      for (int i = 0; i < NUM_TAPS; i++)
        if (addr_q == 16'(i)) coef_q[i] <= wdata_q;
      if (addr_q == ADDR_MASK) mask_q <= wdata_q[6:0];
    end
  end

  // A legal time write wins over a prescaler wrap landing on the same edge.
  always_comb begin
    hour_d   = hour_q;
    minute_d = minute_q;
    pre_d    = pre_q + 36'd1;
    if (time_wr) begin
      pre_d = '0;
      if (addr_q == ADDR_HOUR) hour_d   = wdata_q[4:0];
      else                     minute_d = wdata_q[5:0];
    end else if (pre_q == MINUTE_TICKS - 36'd1) begin
      pre_d = '0;
      if (minute_q == 6'd59) begin
        minute_d = '0;
        hour_d   = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      end else begin
        minute_d = minute_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hour_q <= '0; minute_q <= '0; pre_q <= '0;
    end else begin
      hour_q <= hour_d; minute_q <= minute_d; pre_q <= pre_d;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_TAPS; i++)
      if (mask_q[i]) sum = sum + 19'(coef_q[i]) * 19'(x_q[i]);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      shift_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (!pe_n) begin
        x_q[0] <= sig_in;
        for (int i = 1; i < NUM_TAPS; i++) x_q[i] <= x_q[i-1];
      end
      shift_q <= ~pe_n;
      if (shift_q) result_q <= (sum > 19'(MAX_RESULT)) ? MAX_RESULT : sum[9:0];
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (addr_q)
      ADDR_COEF0:  rdata = coef_q[0];
      ADDR_COEF1:  rdata = coef_q[1];
      ADDR_COEF2:  rdata = coef_q[2];
      ADDR_COEF3:  rdata = coef_q[3];
      ADDR_COEF4:  rdata = coef_q[4];
      ADDR_COEF5:  rdata = coef_q[5];
      ADDR_COEF6:  rdata = coef_q[6];
      ADDR_MASK:   rdata = {1'b0, mask_q};
      ADDR_HOUR:   rdata = {3'b0, hour_q};
      ADDR_MINUTE: rdata = {2'b0, minute_q};
      default:     rdata = 8'h00;
    endcase
  end

  assign dbus = (!cs_n && !r_n) ? rdata : 8'hzz;

  always_comb begin
    if (hour_q == 5'd0)       h12 = 5'd12;
    else if (hour_q > 5'd12)  h12 = hour_q - 5'd12;
    else                      h12 = hour_q;
    dig_val[0] = 4'(result_q % 10'd10);
    dig_val[1] = 4'((result_q / 10'd10) % 10'd10);
    dig_val[2] = 4'(result_q / 10'd100);
    dig_val[3] = 4'(minute_q % 6'd10);
    dig_val[4] = 4'(minute_q / 6'd10);
    dig_val[5] = 4'((h12 >= 5'd10) ? h12 - 5'd10 : h12);
    dig_val[6] = (h12 >= 5'd10) ? 4'd1 : 4'd0;
  end

  for (genvar g = 0; g < 7; g++) begin : g_dig
    seg7_decode u_dec (.digit_i(dig_val[g]), .seg_o(dig_seg[g]));
  end

  assign sig_digi0    = dig_seg[0];
  assign sig_digi1    = dig_seg[1];
  assign sig_digi2    = dig_seg[2];
  assign minute_digi0 = dig_seg[3];
  assign minute_digi1 = dig_seg[4];
  assign hour_digi0   = dig_seg[5];
  assign hour_digi1   = dig_seg[6];
  assign ap           = (hour_q < 5'd12) ? AP_A : AP_P;
endmodule

// File: tb/tb_th99_chls.sv
// Randomised bench for th99_chls against a behavioural model of registers,
// sample history and wall-clock time, plus hand-derived literal checks.
module tb_th99_chls;
  localparam int TICKS = 10;
  localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clock = 1'b0, rst_n = 1'b0;
  logic cs_n, ale, r_n, w_n, pe_n, drv_en;
  logic [7:0] abus, drv, sig_in, rd;
  wire  [7:0] dbus;
  logic [6:0] sig_digi2, sig_digi1, sig_digi0, hour_digi1, hour_digi0;
  logic [6:0] minute_digi1, minute_digi0;
  logic [15:0] ap;

  assign dbus = drv_en ? drv : 8'hzz;
  always #5 clock = ~clock;

  th99_chls #(.CLK_FREQ_HZ(1), .MINUTE_TICKS(36'(TICKS))) dut (
    .clock(clock), .rst_n(rst_n), .cs_n(cs_n), .abus(abus), .ale(ale),
    .r_n(r_n), .w_n(w_n), .dbus(dbus), .pe_n(pe_n), .sig_in(sig_in),
    .sig_digi2(sig_digi2), .sig_digi1(sig_digi1), .sig_digi0(sig_digi0),
    .hour_digi1(hour_digi1), .hour_digi0(hour_digi0),
    .minute_digi1(minute_digi1), .minute_digi0(minute_digi0), .ap(ap));

  int tests = 0, fails = 0;
  bit chk_en = 0, rand_samp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_coef[7];
  int m_mask, m_hour, m_min, m_cnt, m_res, tot;
  bit m_shifted, m_tw;
  int m_hist[$];
  bit wr_pend = 0;
  int wr_addr, wr_data;

  function automatic int fir_now();
    int s = 0;
    for (int i = 0; i < 7 && i < m_hist.size(); i++)
      if (m_mask[i]) s += m_coef[i] * m_hist[i];
    return (s > 999) ? 999 : s;
  endfunction

  function automatic int model_reg(input int a);
    if (a < 7) return m_coef[a];
    if (a == 7) return m_mask;
    if (a == 8) return m_hour;
    if (a == 9) return m_min;
    return 0;
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_coef[i]) m_coef[i] = 0;
      m_mask = 0; m_hour = 0; m_min = 0; m_cnt = 0; m_res = 0;
      m_shifted = 0; wr_pend = 0;
      m_hist.delete();
    end else begin
      m_tw = 0;
      if (m_shifted) m_res = fir_now();
      if (wr_pend) begin
        wr_pend = 0;
        if (wr_addr < 7) m_coef[wr_addr] = wr_data;
        else if (wr_addr == 7) m_mask = wr_data & 'h7F;
        else if (wr_addr == 8 && wr_data < 24) begin m_hour = wr_data; m_tw = 1; end
        else if (wr_addr == 9 && wr_data < 60) begin m_min = wr_data; m_tw = 1; end
      end
      if (m_tw) m_cnt = 0;
      else begin
        m_cnt++;
        if (m_cnt == TICKS) begin
          m_cnt = 0;
          tot = (m_hour * 60 + m_min + 1) % 1440;
          m_hour = tot / 60; m_min = tot % 60;
        end
      end
      if (!pe_n) begin
        m_hist.push_front(int'(sig_in));
        if (m_hist.size() > 7) void'(m_hist.pop_back());
      end
      m_shifted = !pe_n;
    end
  end

  int h12;
  always @(negedge clock) begin
    if (chk_en) begin
      h12 = (m_hour % 12 == 0) ? 12 : m_hour % 12;
      chk("sig2", sig_digi2, SEG[m_res / 100]);
      chk("sig1", sig_digi1, SEG[(m_res / 10) % 10]);
      chk("sig0", sig_digi0, SEG[m_res % 10]);
      chk("hour1", hour_digi1, SEG[h12 / 10]);
      chk("hour0", hour_digi0, SEG[h12 % 10]);
      chk("min1", minute_digi1, SEG[m_min / 10]);
      chk("min0", minute_digi0, SEG[m_min % 10]);
      chk("ap", ap, (m_hour < 12) ? 16'h03CF : 16'h03C7);
    end
  end

  always @(negedge clock) begin
    if (rand_samp) begin
      pe_n   = ($urandom_range(0, 2) == 0);
      sig_in = 8'($urandom);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clock); cs_n = 0; abus = addr[15:8]; drv = addr[7:0]; drv_en = 1; ale = 1;
    @(negedge clock); ale = 0;
    @(negedge clock);
    @(negedge clock); drv = data; w_n = 0;
    @(negedge clock); w_n = 1;
    @(negedge clock); wr_addr = int'(addr); wr_data = int'(data); wr_pend = 1;
    @(negedge clock); cs_n = 1; drv_en = 0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] d);
    @(negedge clock); cs_n = 0; abus = addr[15:8]; drv = addr[7:0]; drv_en = 1; ale = 1;
    @(negedge clock); ale = 0;
    @(negedge clock);
    @(negedge clock); drv_en = 0; r_n = 0;
    #1 d = dbus;
    chk("readback", dbus, model_reg(int'(addr)));
    @(negedge clock); r_n = 1; cs_n = 1;
  endtask

  task automatic chk_res(input string nm, input int v);
    chk({nm, "_d2"}, sig_digi2, SEG[v / 100]);
    chk({nm, "_d1"}, sig_digi1, SEG[(v / 10) % 10]);
    chk({nm, "_d0"}, sig_digi0, SEG[v % 10]);
  endtask

  task automatic chk_time(input string nm, input logic [6:0] h1, h0, n1, n0,
                          input logic [15:0] a);
    chk({nm, "_h1"}, hour_digi1, h1);
    chk({nm, "_h0"}, hour_digi0, h0);
    chk({nm, "_m1"}, minute_digi1, n1);
    chk({nm, "_m0"}, minute_digi0, n0);
    chk({nm, "_ap"}, ap, a);
  endtask

  // Mask 0x0F, coef {1,2,3,0,...}, ramp from 65: 65, 196, then 6n-8.
  function automatic int fir0f(input int n);
    return (n == 65) ? 65 : (n == 66) ? 196 : 6 * n - 8;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", fails);
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  wd;
    int sel;
    cs_n = 1; ale = 0; r_n = 1; w_n = 1; abus = 0; drv = 0; drv_en = 0;
    pe_n = 1; sig_in = 0;
    repeat (3) @(negedge clock);
    rst_n = 1;
    @(negedge clock); chk_en = 1;
    chk_res("rst_sig", 0);
    chk_time("rst_time", 7'h06, 7'h5B, 7'h3F, 7'h3F, 16'h03CF);

    bus_write(16'd8, 8'd10);
    bus_write(16'd9, 8'd30);
    chk_time("t1030", 7'h06, 7'h3F, 7'h4F, 7'h3F, 16'h03CF);
    bus_read(16'd8, rd); chk("rd_hour", rd, 8'd10);
    bus_write(16'd9, 8'd30);
    bus_read(16'd9, rd); chk("rd_min", rd, 8'd30);

    bus_write(16'd8, 8'd11);
    bus_write(16'd9, 8'd59);
    repeat (12) @(negedge clock);
    chk_time("wrap_pm", 7'h06, 7'h5B, 7'h3F, 7'h3F, 16'h03C7);
    bus_write(16'd8, 8'd23);
    bus_write(16'd9, 8'd59);
    repeat (12) @(negedge clock);
    chk_time("wrap_am", 7'h06, 7'h5B, 7'h3F, 7'h3F, 16'h03CF);

    bus_write(16'd8, 8'd24);
    bus_write(16'd9, 8'd60);
    bus_write(16'h0100, 8'h55);
    bus_read(16'd8, rd); chk("illegal_hour", rd, 8'd0);
    bus_read(16'd9, rd);
    bus_read(16'h0100, rd); chk("unmapped_rd", rd, 8'd0);

    bus_write(16'd0, 8'd1); bus_write(16'd1, 8'd2); bus_write(16'd2, 8'd3);
    bus_write(16'd3, 8'd0); bus_write(16'd4, 8'd1); bus_write(16'd5, 8'd2);
    bus_write(16'd6, 8'd3); bus_write(16'd7, 8'h0F);
    for (int n = 65; n <= 79; n++) begin
      @(negedge clock); pe_n = 0; sig_in = 8'(n);
      if (n >= 67) chk_res("fir0f", fir0f(n - 2));
    end
    @(negedge clock); pe_n = 1;
    repeat (2) @(negedge clock);
    chk_res("fir0f_end", 466);
    repeat (5) @(negedge clock);
    chk_res("fir0f_hold", 466);

    bus_write(16'd7, 8'h7F);
    for (int n = 65; n <= 71; n++) begin
      @(negedge clock); pe_n = 0; sig_in = 8'(n);
    end
    @(negedge clock); pe_n = 1;
    repeat (2) @(negedge clock);
    chk_res("fir7f", 812);
    for (int n = 0; n < 7; n++) begin
      @(negedge clock); pe_n = 0; sig_in = 8'd255;
    end
    @(negedge clock); pe_n = 1;
    repeat (2) @(negedge clock);
    chk_res("fir_sat", 999);

    rand_samp = 1;
    repeat (300) begin
      sel = $urandom_range(0, 11);
      ra  = (sel == 11) ? 16'h0100 : 16'(sel);
      wd  = 8'($urandom);
      if (sel == 8) wd = 8'($urandom_range(0, 30));
      if (sel == 9) wd = 8'($urandom_range(0, 70));
      case ($urandom_range(0, 3))
        0, 1: bus_write(ra, wd);
        2:    bus_read(ra, rd);
        default: repeat ($urandom_range(1, 5)) @(negedge clock);
      endcase
    end

    // Reset in the middle of a write to the hour register must abort it.
    rand_samp = 0;
    @(negedge clock); pe_n = 0; cs_n = 0; abus = 0; drv = 8'd8; drv_en = 1; ale = 1;
    @(negedge clock); ale = 0;
    @(negedge clock);
    @(negedge clock); drv = 8'd5; w_n = 0;
    #2 rst_n = 0;
    @(negedge clock); w_n = 1; cs_n = 1; drv_en = 0; pe_n = 1;
    chk_res("midrst_sig", 0);
    chk_time("midrst_time", 7'h06, 7'h5B, 7'h3F, 7'h3F, 16'h03CF);
    @(negedge clock); rst_n = 1;
    bus_read(16'd8, rd); chk("midrst_hour", rd, 8'd0);
    bus_read(16'd0, rd); chk("midrst_coef", rd, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
